// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the MEM-stage request demultiplexer.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAM_WAIT,
    ST_IO_WAIT,
    ST_DONE
  } demux_state_e;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;
  localparam logic [1:0]  ALIGN_MASK      = 2'b11;
  localparam int unsigned TIMEOUT_CTR_W   = 8;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_req_demux_if.sv
// Pipeline request, completion and per-target handshake bundle for mem_req_demux.
interface mem_req_demux_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              stall;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              err;

  logic              ram_valid;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ready;
  logic [DATA_W-1:0] ram_rdata;

  logic              io_valid;
  logic              io_write;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_ready;
  logic [DATA_W-1:0] io_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output stall, rdata, rdata_valid, err,
    output ram_valid, ram_write, ram_addr, ram_wdata,
    input  ram_ready, ram_rdata,
    output io_valid, io_write, io_addr, io_wdata,
    input  io_ready, io_rdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  stall, rdata, rdata_valid, err,
    input  ram_valid, ram_write, ram_addr, ram_wdata,
    output ram_ready, ram_rdata,
    input  io_valid, io_write, io_addr, io_wdata,
    output io_ready, io_rdata
  );

endinterface

// File: rtl/bus_timeout_ctr.sv
// Loadable down-counter with clear and enable; expired while the count sits at zero.
module bus_timeout_ctr #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/mem_req_demux.sv
// Fans the MEM-stage data request out to RAM or the I/O window and returns the
// completion with a registered result, stall, and sticky bus error.
module mem_req_demux
  import mem_bus_pkg::*;
#(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT),
  parameter int unsigned       TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_req_demux_if.master   bus
);

  // Loaded with TIMEOUT-1 so expiry lands on the TIMEOUT-th wait cycle.
  localparam logic [TIMEOUT_CTR_W-1:0] TO_LOAD = TIMEOUT_CTR_W'(TIMEOUT - 1);

  demux_state_e      state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ram_valid_q, ram_valid_d;
  logic              io_valid_q, io_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              err_q, err_d;

  logic ctr_clr, ctr_load, ctr_en, ctr_expired;

  bus_timeout_ctr #(
    .W (TIMEOUT_CTR_W)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ctr_clr),
    .load     (ctr_load),
    .load_val (TO_LOAD),
    .en       (ctr_en),
    .expired  (ctr_expired)
  );

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    ram_valid_d   = 1'b0;
    io_valid_d    = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    err_d         = err_q;
    ctr_clr       = 1'b0;
    ctr_load      = 1'b0;
    ctr_en        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ctr_clr = 1'b1;
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (!is_aligned(bus.req_addr[1:0])) begin
            state_d       = ST_DONE;
            rdata_d       = '0;
            rdata_valid_d = 1'b1;
            err_d         = 1'b1;
          end else if (bus.req_addr >= IO_BASE) begin
            state_d    = ST_IO_WAIT;
            io_valid_d = 1'b1;
            ctr_load   = 1'b1;
          end else begin
            state_d     = ST_RAM_WAIT;
            ram_valid_d = 1'b1;
            ctr_load    = 1'b1;
          end
        end
      end

      ST_RAM_WAIT: begin
        if (bus.ram_ready) begin
          state_d       = ST_DONE;
          rdata_d       = write_q ? '0 : bus.ram_rdata;
          rdata_valid_d = 1'b1;
        end else if (ctr_expired) begin
          state_d       = ST_DONE;
          rdata_d       = '0;
          rdata_valid_d = 1'b1;
          err_d         = 1'b1;
        end else begin
          ram_valid_d = 1'b1;
          ctr_en      = 1'b1;
        end
      end

      ST_IO_WAIT: begin
        if (bus.io_ready) begin
          state_d       = ST_DONE;
          rdata_d       = write_q ? '0 : bus.io_rdata;
          rdata_valid_d = 1'b1;
        end else if (ctr_expired) begin
          state_d       = ST_DONE;
          rdata_d       = '0;
          rdata_valid_d = 1'b1;
          err_d         = 1'b1;
        end else begin
          io_valid_d = 1'b1;
          ctr_en     = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      ram_valid_q   <= 1'b0;
      io_valid_q    <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      ram_valid_q   <= ram_valid_d;
      io_valid_q    <= io_valid_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
    end
  end

  assign bus.stall       = ((state_q == ST_IDLE) && bus.req_valid) ||
                           (state_q == ST_RAM_WAIT) || (state_q == ST_IO_WAIT);
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.err         = err_q;

  assign bus.ram_valid   = ram_valid_q;
  assign bus.ram_write   = write_q;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_wdata   = wdata_q;

  assign bus.io_valid    = io_valid_q;
  assign bus.io_write    = write_q;
  assign bus.io_addr     = addr_q;
  assign bus.io_wdata    = wdata_q;

endmodule
